trans_unbuf: RTL
================

// Module: trans_unbuf
// PURPOSE
//  Parallel-to-serial counterpart of the layer input collector.
//  - Captures one DEPTH-word frame, presented in parallel with a one-cycle valid pulse.
//  - Streams the frame out one WIDTH-bit word per beat, index 0 first.
//  - Output uses a valid/ready handshake; the next serial stage may stall it.
//  - Sits between a layer that produces a whole frame at once and a word-serial consumer.
// PARAMETERS
//  DEPTH  884  words per frame (>=2)
//  WIDTH  32   bits per word
//  IDXW   11   index width, must satisfy 2**IDXW >= DEPTH
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  valid_in   in   1            one-cycle frame-present pulse
//  data_in    in   WIDTH x DEPTH unpacked array [0:DEPTH-1]; sampled only on accept
//  in_ready   out  1            block can accept a frame this cycle
//  drop       out  1            one-cycle pulse: valid_in seen while in_ready=0
//  valid_out  out  1            data_out holds a word
//  ready_out  in   1            downstream accepts the word this cycle
//  data_out   out  WIDTH        current word; 0 when valid_out=0
//  last_out   out  1            high with valid_out on word DEPTH-1
//  idx_out    out  IDXW         index of the current word; 0 when idle
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, idx=0.
//   - in_ready=1, valid_out=0, drop=0, last_out=0, data_out=0.
//   - Frame buffer is not reset.
//  Handshakes:
//   - Accept: valid_in && in_ready on the same edge.
//   - Beat: valid_out && ready_out on the same edge.
//  States (in_ready is 1 only in IDLE):
//   - IDLE: on accept, buf <= data_in (all DEPTH words in one edge), idx <= 0,
//     state <= STREAM. Otherwise hold.
//   - STREAM: valid_out=1, data_out=buf[idx], idx_out=idx, last_out=(idx==DEPTH-1).
//     On a beat with idx<DEPTH-1: idx <= idx+1.
//     On a beat with idx==DEPTH-1: idx <= 0, state <= IDLE.
//     With ready_out=0: idx, data_out and last_out hold; valid_out never drops mid-frame.
//  Latency:
//   - Accept at edge N gives valid_out=1, word 0 visible after edge N.
//   - With ready_out held at 1, the frame takes exactly DEPTH beats.
//   - in_ready returns to 1 after the edge carrying the last beat.
//   - A new frame may be accepted on the very next edge, so frame spacing is DEPTH+1 cycles.
//  Drop:
//   - valid_in while in_ready=0 (including the cycle of the last beat) is ignored.
//   - drop is registered high for exactly one cycle after that edge.
//   - buf and idx are unaffected.
//  Boundaries:
//   - idx never exceeds DEPTH-1 and never wraps within a frame.
//   - ready_out toggling every cycle gives no skipped or repeated words.
//   - ready_out=1 while valid_out=0 has no effect.
//  Reset mid-frame: the stream aborts immediately and outputs take their reset values;
//   the next accepted frame starts at index 0.
//  Data: words pass through bit-exact, with no arithmetic on data.
// TESTING
//  T1 reset: rst_n=0 mid-run -> in_ready=1, valid_out=0, idx_out=0, data_out=0 on the
//     same cycle, with no clock needed.
//  T2 basic frame: data_in[k]=32'hA000_0000+k, pulse valid_in, ready_out=1 ->
//     884 beats with data_out=A000_0000..A000_0373, last_out only on idx 883,
//     then in_ready=1.
//  T3 backpressure: ready_out random (~50%) -> output sequence identical to T2;
//     data_out stable whenever valid_out=1 and ready_out=0.
//  T4 overlap: valid_in pulsed at beat 100 and at the last-beat edge ->
//     drop pulses twice, stream unchanged.
//     valid_in on the next edge is accepted, and its word 0 appears on the following cycle.
//  T5 back-to-back: two frames (0x1000+k, then 0x2000+k) sent with minimum spacing ->
//     1768 beats in order with exactly one idle cycle between frames.
//  T6 reset mid-frame: rst_n low at idx 500, then release and send a frame of 0xB000+k ->
//     the output restarts at 0xB000 and idx 0.

Source files
------------

// File: rtl/trans_unbuf.sv
// trans_unbuf: captures a DEPTH-word parallel frame and streams it out one word per valid/ready beat
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_in, data_in  one-cycle frame pulse with DEPTH parallel words
//   in_ready, drop     frame accept window (IDLE only), pulse for a frame seen while busy
//   valid_out, ready_out, data_out, last_out, idx_out  serial word stream, index 0 first
module trans_unbuf #(
  parameter int DEPTH = 884,
  parameter int WIDTH = 32,
  parameter int IDXW  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in [0:DEPTH-1],
  output logic             in_ready,
  output logic             drop,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             last_out,
  output logic [IDXW-1:0]  idx_out
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;
  logic [IDXW-1:0] idx, idx_nx;
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic at_last, accept, beat;
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    in_ready  = state == IDLE;
    valid_out = state == STREAM;
    at_last   = idx == IDXW'(DEPTH - 1);
    accept    = valid_in && in_ready;
    beat      = valid_out && ready_out;
    data_out  = valid_out ? mem[idx] : '0;
    last_out  = valid_out && at_last;
    idx_out   = valid_out ? idx : '0;
    if (accept) begin
      state_nx = STREAM;
      idx_nx   = '0;
    end else if (beat) begin
      state_nx = at_last ? IDLE : STREAM;
      idx_nx   = at_last ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      drop  <= valid_in && !in_ready;
    end
  // frame storage carries no reset; it is only read while streaming a captured frame
  always_ff @(posedge clk)
    if (accept) mem <= data_in;
endmodule
